uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
- Transmit-side counterpart of the IO hub's UART receive path and header parser.
- Takes 16-bit words from the hub's outbound FIFO/FSM through a valid/ready handshake.
- Frames each word as header byte, MSB, then LSB, and serialises the bytes onto the UART TX line as 8N1.
- Contains its own baud divider and bit-level transmitter, so no external UART core is needed.

Parameters:
- CLK_DIV, 434, clk_i cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- HEADER, 8'h40, frame header byte sent before each word.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  reset; asynchronous, active-high
- word_i  input  16  word to transmit
- valid_i  input  1  word_i is valid
- ready_o  output  1  block can accept a word (IDLE)
- tx_o  output  1  UART serial output; idle level high
- busy_o  output  1  frame in progress
- frame_done_o  output  1  one-cycle pulse when the last stop bit has completed

Behaviour:
- Reset values (asynchronous, take effect immediately, including mid-frame):
  - tx_o=1, ready_o=1, busy_o=0, frame_done_o=0.
  - Bit counter, baud counter and byte index cleared; word latch cleared.
- Handshake:
  - Transfer occurs on a rising edge with valid_i=1 and ready_o=1.
  - word_i is latched on that edge; later changes to word_i have no effect.
  - While busy_o=1, valid_i is ignored: no acceptance and no queueing.
- ready_o = ~busy_o, all outputs registered.
- Byte sequencer: byte index 0=HEADER, 1=word[15:8], 2=word[7:0].
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept; tx_o drives 0 from the cycle after the accept edge.
  - START: tx_o=0 for CLK_DIV cycles, then -> DATA.
  - DATA: 8 bits LSB first, each held exactly CLK_DIV cycles, then -> STOP.
  - STOP: tx_o=1 for CLK_DIV cycles.
    - If more bytes remain: increment byte index and go directly to START, with no idle gap.
    - Otherwise: go to IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 and wraps at CLK_DIV-1; that wrap advances the bit.
  - Reloads to 0 on accept.
- Frame length is exactly 30*CLK_DIV cycles from the first start-bit cycle to the end of the last stop bit.
- Frame end, all in the same edge: frame_done_o=1 for one cycle, busy_o falls, ready_o rises.
  - A word may be accepted on the first cycle that ready_o=1.
  - Back-to-back frames therefore have zero idle bit-times between them.
- Reset mid-frame: the frame is aborted and no frame_done_o pulse is produced. After reset release the block is in IDLE.
- Counter width: $clog2(CLK_DIV) bits minimum. No arithmetic overflow is possible within the legal range.

Optional Feature:
- Macro: UART_WORD_TX_CHKSUM_EN.
- When defined:
  - A 4th byte (index 3) is sent after the LSB.
  - chk = (0 - (HEADER + word[15:8] + word[7:0])) mod 256, so the 8-bit sum of all four bytes is 0.
  - Frame length becomes 40*CLK_DIV cycles.
  - frame_done_o pulses after the checksum byte's stop bit.
- When not defined:
  - Frames are 3 bytes.
  - No checksum logic is instantiated.

Test Plan (CLK_DIV=4, HEADER=8'h40):
- Single word: word_i=16'h1234 accepted.
  - Required tx_o bytes: 8'h40, 8'h12, 8'h34, each 0+8 data LSB-first+1, 40 cycles per byte.
  - frame_done_o pulses at cycle 120 after the first start bit.
  - ready_o is low for exactly 120 cycles.
- Busy ignore: hold valid_i=1 with word 16'hAAAA during the frame of 16'h1234.
  - Only 16'h1234 is sent.
  - 16'hAAAA is accepted on the frame_done_o cycle, and its start bit follows immediately with no idle gap.
- Word change after accept: change word_i to 16'hFFFF on the cycle after accepting 16'h0001 -> transmitted bytes are 40, 00, 01.
- Reset mid-frame: assert rst_i during DATA of byte 1.
  - tx_o=1 asynchronously, ready_o=1, no frame_done_o pulse.
  - A new word 16'h00FF then transmits cleanly as 40, 00, FF.
- Checksum (UART_WORD_TX_CHKSUM_EN defined): word 16'h1234 -> bytes 40, 12, 34, 7A; frame is 160 cycles.
- Idle line: no valid_i for 1000 cycles -> tx_o stays 1, busy_o stays 0, frame_done_o never pulses.

Source files
------------

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_word_tx
//  Purpose  : Accepts 16-bit words over a valid/ready handshake and sends each
//             one on an 8N1 UART line as a frame: HEADER, word[15:8], word[7:0].
//             The baud divider and bit serialiser are built in.
//             Optional macro UART_WORD_TX_CHKSUM_EN appends a fourth byte. Its
//             value makes the 8-bit sum of all four bytes equal zero.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_word_tx #(
    parameter int unsigned CLK_DIV = 434,      // clk_i cycles per UART bit
    parameter logic [7:0]  HEADER  = 8'h40     // frame header byte
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] word_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        tx_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    localparam int              c_CNT_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_BAUD_ONE  = c_CNT_W'(1);
`ifdef UART_WORD_TX_CHKSUM_EN
    localparam logic [1:0]      c_LAST_BYTE = 2'd3;
`else
    localparam logic [1:0]      c_LAST_BYTE = 2'd2;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [2:0]           r_bit_idx;
    logic [1:0]           r_byte_idx;
    logic [15:0]          r_word;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_ready;
    logic                 r_done;
    logic [7:0]           w_cur_byte;
    logic                 w_baud_wrap;

`ifdef UART_WORD_TX_CHKSUM_EN
    logic [7:0]           w_chk;
    // Two's-complement negation of the byte sum, so all four bytes sum to zero
    assign w_chk = 8'h00 - (HEADER + r_word[15:8] + r_word[7:0]);
`endif

    assign w_baud_wrap = (r_baud_cnt == c_BAUD_LAST);

    // Select the byte to serialise from the current position in the frame
    always_comb begin
        w_cur_byte = HEADER;
        case (r_byte_idx)
            2'd0:    w_cur_byte = HEADER;
            2'd1:    w_cur_byte = r_word[15:8];
            2'd2:    w_cur_byte = r_word[7:0];
`ifdef UART_WORD_TX_CHKSUM_EN
            default: w_cur_byte = w_chk;
`else
            default: w_cur_byte = HEADER;
`endif
        endcase
    end

    // Bit-level FSM, baud divider, byte sequencer and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_word     <= 16'h0000;
            r_shift    <= 8'h00;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        // Accept: latch the word and start the header's start bit next cycle
                        r_word     <= word_i;
                        r_byte_idx <= 2'd0;
                        r_bit_idx  <= 3'd0;
                        r_baud_cnt <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_wrap) begin
                        // Put the LSB on the line now and keep the rest for later bits
                        r_baud_cnt <= '0;
                        r_bit_idx  <= 3'd0;
                        r_tx       <= w_cur_byte[0];
                        r_shift    <= {1'b0, w_cur_byte[7:1]};
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (r_byte_idx == c_LAST_BYTE) begin
                            // Frame complete: done pulse and ready rise on the same edge
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            // Next byte's start bit follows the stop bit with no gap
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o         = r_tx;
    assign busy_o       = r_busy;
    assign ready_o      = r_ready;
    assign frame_done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_word_tx
//  Purpose  : Self-checking bench for uart_word_tx (CLK_DIV=4, HEADER=8'h40)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_word_tx;

    localparam int unsigned c_DIV = 4;
    localparam logic [7:0]  c_HDR = 8'h40;
`ifdef UART_WORD_TX_CHKSUM_EN
    localparam int c_NB = 4;
`else
    localparam int c_NB = 3;
`endif
    localparam int c_FRAME = c_NB * 10 * c_DIV;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic [15:0] word_i  = 16'h0000;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        tx_o;
    logic        busy_o;
    logic        frame_done_o;

    int checks   = 0;
    int failures = 0;

    uart_word_tx #(.CLK_DIV(c_DIV), .HEADER(c_HDR)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .word_i       (word_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference byte k of the frame for word w, from the framing rules
    function automatic logic [7:0] model_byte(input logic [15:0] w, input int k);
        int hi, lo, s;
        hi = int'(w) / 256;
        lo = int'(w) % 256;
        s  = (int'(c_HDR) + hi + lo) % 256;
        case (k)
            0:       return c_HDR;
            1:       return 8'(hi);
            2:       return 8'(lo);
            default: return 8'((256 - s) % 256);
        endcase
    endfunction

    // Wait (bounded) for ready_o at a negedge
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready_o !== 1'b1 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        if (ready_o !== 1'b1) check({name, ".ready_timeout"}, 0, 1);
    endtask

    // Called at a negedge with valid_i/word_i set and ready_o high. Checks the
    // whole line waveform cycle by cycle, then the frame-end cycle.
    task automatic check_frame(input logic [7:0] hi, input logic [7:0] lo,
                               input logic [15:0] w_after, input logic v_after,
                               input string name);
        logic [7:0] bytes [4];
        logic       exp_q [$];
        int         bad_tx, bad_hs, first_bad;
        bytes[0] = c_HDR;
        bytes[1] = hi;
        bytes[2] = lo;
        bytes[3] = 8'((256 - ((int'(c_HDR) + int'(hi) + int'(lo)) % 256)) % 256);
        exp_q = {};
        for (int k = 0; k < c_NB; k++)
            for (int j = 0; j < 10; j++)
                for (int c = 0; c < int'(c_DIV); c++)
                    exp_q.push_back((j == 0) ? 1'b0 : (j == 9) ? 1'b1 : bytes[k][j-1]);
        @(negedge clk_i);
        word_i  = w_after;
        valid_i = v_after;
        bad_tx = 0; bad_hs = 0; first_bad = -1;
        for (int i = 0; i < c_FRAME; i++) begin
            if (tx_o !== exp_q[i]) begin
                bad_tx++;
                if (first_bad < 0) first_bad = i;
            end
            if (busy_o !== 1'b1 || ready_o !== 1'b0 || frame_done_o !== 1'b0) bad_hs++;
            @(negedge clk_i);
        end
        check({name, ".tx_bits"}, bad_tx, 0);
        if (bad_tx != 0) $display("  first tx difference at frame cycle %0d", first_bad);
        check({name, ".busy_window"}, bad_hs, 0);
        check({name, ".done"},  int'(frame_done_o), 1);
        check({name, ".ready"}, int'(ready_o), 1);
        check({name, ".busy"},  int'(busy_o), 0);
        check({name, ".tx_idle"}, int'(tx_o), 1);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] word_after;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int bad;
        logic [15:0] w, next_w;
        logic        pending, b2b;

        tbl[0] = '{16'h1234, 16'h0000, 8'h12, 8'h34};
        tbl[1] = '{16'h0001, 16'hFFFF, 8'h00, 8'h01};
        tbl[2] = '{16'hFFFF, 16'h5555, 8'hFF, 8'hFF};
        tbl[3] = '{16'h0000, 16'hFFFF, 8'h00, 8'h00};
        tbl[4] = '{16'hA55A, 16'h0000, 8'hA5, 8'h5A};

        // Reset state
        repeat (2) @(negedge clk_i);
        check("reset.tx",    int'(tx_o), 1);
        check("reset.ready", int'(ready_o), 1);
        check("reset.busy",  int'(busy_o), 0);
        check("reset.done",  int'(frame_done_o), 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Table-driven frames (includes word change after accept)
        for (int t = 0; t < 5; t++) begin
            wait_ready($sformatf("tbl%0d", t));
            word_i  = tbl[t].word;
            valid_i = 1'b1;
            check_frame(tbl[t].exp_hi, tbl[t].exp_lo, tbl[t].word_after, 1'b0,
                        $sformatf("tbl%0d", t));
            @(negedge clk_i);
            check($sformatf("tbl%0d.done_one_cycle", t), int'(frame_done_o), 0);
        end

        // Busy ignore: AAAA held during 1234's frame, accepted on the done cycle
        wait_ready("busy_ign");
        word_i  = 16'h1234;
        valid_i = 1'b1;
        check_frame(8'h12, 8'h34, 16'hAAAA, 1'b1, "busy_ign");
        check_frame(8'hAA, 8'hAA, 16'h0000, 1'b0, "busy_next");

        // Reset mid-frame during data bits of byte 1
        @(negedge clk_i);
        word_i  = 16'h1234;
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (49) @(negedge clk_i);
        check("midrst.pre_busy", int'(busy_o), 1);
        #2 rst_i = 1'b1;
        #1;
        check("midrst.tx",    int'(tx_o), 1);
        check("midrst.ready", int'(ready_o), 1);
        check("midrst.busy",  int'(busy_o), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (frame_done_o !== 1'b0 || tx_o !== 1'b1) bad++;
        end
        rst_i = 1'b0;
        repeat (100) begin
            @(negedge clk_i);
            if (frame_done_o !== 1'b0 || tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        check("midrst.quiet_after", bad, 0);
        word_i  = 16'h00FF;
        valid_i = 1'b1;
        check_frame(8'h00, 8'hFF, 16'h0000, 1'b0, "after_rst");

        // Idle line for 1000 cycles
        bad = 0;
        @(negedge clk_i);
        repeat (1000) begin
            if (tx_o !== 1'b1 || busy_o !== 1'b0 || frame_done_o !== 1'b0 || ready_o !== 1'b1) bad++;
            @(negedge clk_i);
        end
        check("idle_1000", bad, 0);

        // Randomised words against the reference model, some back-to-back
        pending = 1'b0;
        next_w  = 16'($urandom);
        for (int it = 0; it < 16; it++) begin
            w      = next_w;
            next_w = 16'($urandom);
            if (!pending) begin
                bad = 0;
                repeat ($urandom_range(0, 3)) begin
                    if (tx_o !== 1'b1 || ready_o !== 1'b1) bad++;
                    @(negedge clk_i);
                end
                check($sformatf("rand%0d.gap_idle", it), bad, 0);
                word_i  = w;
                valid_i = 1'b1;
            end
            b2b = 1'($urandom_range(0, 1));
            check_frame(model_byte(w, 1), model_byte(w, 2),
                        b2b ? next_w : 16'($urandom), b2b, $sformatf("rand%0d", it));
            pending = b2b;
        end
        valid_i = 1'b0;
        repeat (c_FRAME + 10) @(negedge clk_i);
        check("final.ready", int'(ready_o), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
